// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared pipeline definitions for the 5-stage core: register-address width,
//   hazard-controller defaults, FSM state encoding and the bundle of stage
//   load-enable / flush controls driven by pipe_hazard_ctrl.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // Architectural register-file address width (32 GPRs, r0 hardwired zero).
    localparam int REG_W = 5;

    // Hazard-controller defaults.
    localparam int DEF_TIMEOUT = 255;  // max data-memory wait cycles
    localparam int DEF_CNT_W   = 16;   // stall performance counter width

    // Hazard-controller FSM. ST_RSVD is never entered on purpose; if it is
    // ever seen (upset, bad init) the FSM falls back to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2,
        ST_RSVD     = 2'd3
    } state_t;

    // Stage controls, pc_en in the MSB.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    // Everything advances, nothing is squashed.
    localparam stage_ctrl_t CTRL_NORMAL = 8'b11111_000;
    // Everything frozen.
    localparam stage_ctrl_t CTRL_HALT   = 8'b00000_000;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Flags a load-use hazard: the instruction in EX is a load whose destination
//   (non-zero) is read by the instruction currently in ID.
//
//   Ports
//     ex_mem_read  in   EX instruction is a load
//     ex_rd        in   EX destination register
//     id_rs        in   ID source register rs
//     id_rt        in   ID source register rt
//     id_uses_rt   in   ID instruction actually reads rt
//     hazard       out  load-use hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rd == id_rs);
    // rt only counts when the ID instruction really sources it (e.g. not for
    // immediate forms that reuse the rt field as a destination).
    assign rt_match = id_uses_rt & (ex_rd == id_rt);

    // r0 is never written, so a load to r0 can never create a dependency.
    assign hazard = ex_mem_read & (ex_rd != '0) & (rs_match | rt_match);

endmodule : load_use_detect

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Stage controls
//   are combinational from the registered FSM state and the current hazard
//   inputs; only the FSM, the memory-wait timer, the stall counter and the
//   sticky error flag are registered.
//
//   Control priority (highest first):
//     ERR > data-memory wait > taken branch > load-use > fetch wait > normal
//
//   Parameters
//     TIMEOUT   max data-memory wait cycles before entering ERR (>= 1)
//     CNT_W     width of the stall performance counter
//
//   Ports
//     clk               in   clock, all state on rising edge
//     rst               in   synchronous active-high reset
//     id_rs, id_rt      in   ID source registers
//     id_uses_rt        in   ID instruction reads rt
//     ex_mem_read       in   EX instruction is a load
//     ex_rd             in   EX destination register
//     ex_branch_taken   in   branch resolved taken in EX
//     dmem_req          in   MEM-stage data access pending
//     dmem_ready        in   data access completes this cycle
//     imem_ready        in   instruction fetch completes this cycle
//     stall_cnt_clr     in   synchronous clear of stall_cnt
//     pc_en .. mem_wb_en      out  stage load enables
//     *_flush                 out  load a bubble into that stage register
//     err               out  sticky timeout error
//     stall_cnt         out  saturating count of stalled-PC cycles
//     state             out  FSM state (debug)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    input  logic             stall_cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    // Timer just wide enough to hold TIMEOUT.
    localparam int unsigned             WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]       TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]        CNT_MAX   = '1;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    stage_ctrl_t       ctrl;
    logic              load_use;
    logic              mem_wait;
    logic              stall_inc;

    // -------------------------------------------------------------------------
    // Hazard detect
    // -------------------------------------------------------------------------
    load_use_detect u_load_use (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hazard      (load_use)
    );

    // A memory wait is either a fresh access that is not ready yet, or an
    // access we are already waiting on (dmem_req may drop while waiting).
    assign mem_wait = (dmem_req & ~dmem_ready) |
                      ((state_q == ST_MEM_WAIT) & ~dmem_ready);

    // -------------------------------------------------------------------------
    // FSM next state and stage controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctrl    = CTRL_NORMAL;

        unique case (state_q)
            ST_RUN: begin
                if (dmem_req & ~dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    wait_d  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT_V) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;   // only rst leaves ERR
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase

        if (rst) begin
            ctrl = CTRL_NORMAL;
        end else if (state_q == ST_ERR) begin
            ctrl = CTRL_HALT;
        end else if (mem_wait) begin
            // Freeze everything up to EX/MEM and feed bubbles into WB. A taken
            // branch sitting in EX stays there and is acted on once the wait
            // ends, so it is never dropped.
            ctrl              = CTRL_HALT;
            ctrl.mem_wb_en    = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, insert one bubble behind the load.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_flush  = 1'b1;
        end else if (~imem_ready) begin
            // Fetch not back yet: hold PC, let ID see a bubble.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_flush  = 1'b1;
        end
    end

    // Stalls are counted only while the pipe is alive; a dead pipe in ERR
    // would otherwise just peg the counter.
    assign stall_inc = ~ctrl.pc_en & (state_q != ST_ERR);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_d == ST_ERR) begin
                err_q <= 1'b1;
            end
            if (stall_cnt_clr) begin
                cnt_q <= '0;
            end else if (stall_inc && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. While rst is held the controller looks like a clean RUN state
    // even before the first reset edge has been taken.
    // -------------------------------------------------------------------------
    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign err          = err_q & ~rst;
    assign state        = rst ? ST_RUN : state_q;
    assign stall_cnt    = cnt_q;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two controllers share one stimulus stream: one with default parameters and
//   one with TIMEOUT=4, CNT_W=2 so the timeout and counter saturation corners
//   are reachable. A driver applies inputs just after each rising edge and
//   queues the expected outputs from a table-driven reference model; a monitor
//   pops and compares on each falling edge. Directed checks with hand-derived
//   constants cover the specific scenarios, followed by a random run.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       ex_mem_read;
        logic [4:0] ex_rd;
        logic       ex_branch_taken;
        logic       dmem_req;
        logic       dmem_ready;
        logic       imem_ready;
        logic       stall_cnt_clr;
    } stim_t;

    // Reference model state: FSM as 0=run 1=wait 2=err, plain integers.
    typedef struct {
        int st;
        int wcnt;
        int scnt;
        int timeout;
        int cmax;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b1, imem_ready = 1'b1, stall_cnt_clr = 1'b0;

    logic        pc_en_f, if_id_en_f, id_ex_en_f, ex_mem_en_f, mem_wb_en_f;
    logic        if_id_flush_f, id_ex_flush_f, mem_wb_flush_f, err_f;
    logic [15:0] stall_cnt_f;
    logic [1:0]  state_f;

    logic        pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s;
    logic        if_id_flush_s, id_ex_flush_s, mem_wb_flush_s, err_s;
    logic [1:0]  stall_cnt_s;
    logic [1:0]  state_s;

    pipe_hazard_ctrl dut_full (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .stall_cnt_clr(stall_cnt_clr),
        .pc_en(pc_en_f), .if_id_en(if_id_en_f), .id_ex_en(id_ex_en_f),
        .ex_mem_en(ex_mem_en_f), .mem_wb_en(mem_wb_en_f), .if_id_flush(if_id_flush_f),
        .id_ex_flush(id_ex_flush_f), .mem_wb_flush(mem_wb_flush_f), .err(err_f),
        .stall_cnt(stall_cnt_f), .state(state_f)
    );

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .stall_cnt_clr(stall_cnt_clr),
        .pc_en(pc_en_s), .if_id_en(if_id_en_s), .id_ex_en(id_ex_en_s),
        .ex_mem_en(ex_mem_en_s), .mem_wb_en(mem_wb_en_s), .if_id_flush(if_id_flush_s),
        .id_ex_flush(id_ex_flush_s), .mem_wb_flush(mem_wb_flush_s), .err(err_s),
        .stall_cnt(stall_cnt_s), .state(state_s)
    );

    // {8 stage controls (pc_en first), err, state[1:0], stall_cnt[15:0]}
    logic [26:0] act_f, act_s;
    assign act_f = {pc_en_f, if_id_en_f, id_ex_en_f, ex_mem_en_f, mem_wb_en_f,
                    if_id_flush_f, id_ex_flush_f, mem_wb_flush_f, err_f, state_f, stall_cnt_f};
    assign act_s = {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s,
                    if_id_flush_s, id_ex_flush_s, mem_wb_flush_s, err_s, state_s,
                    14'b0, stall_cnt_s};

    logic [26:0] q_f[$];
    logic [26:0] q_s[$];
    model_t      mf, ms;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the behavioural rules, evaluated on the inputs
    // currently applied and the model state before the coming edge.
    function automatic logic [26:0] model_expect(input model_t m);
        logic [7:0] c;
        logic       lu, memw, e;
        logic [1:0] st2;
        lu   = ex_mem_read && (ex_rd != 0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        memw = (dmem_req && !dmem_ready) || (m.st == 1 && !dmem_ready);
        if (rst)                  c = 8'b11111_000;
        else if (m.st == 2)       c = 8'b00000_000;
        else if (memw)            c = 8'b00001_001;
        else if (ex_branch_taken) c = 8'b11111_110;
        else if (lu)              c = 8'b00111_010;
        else if (!imem_ready)     c = 8'b01111_100;
        else                      c = 8'b11111_000;
        e   = (m.st == 2) && !rst;
        st2 = rst ? 2'd0 : 2'(m.st);
        return {c, e, st2, 16'(m.scnt)};
    endfunction

    task automatic model_step(inout model_t m, input logic pc_en_exp);
        if (rst) begin
            m.st = 0; m.wcnt = 0; m.scnt = 0;
        end else begin
            if (stall_cnt_clr)                              m.scnt = 0;
            else if (!pc_en_exp && m.st != 2 && m.scnt < m.cmax) m.scnt++;
            case (m.st)
                0: if (dmem_req && !dmem_ready) begin m.st = 1; m.wcnt = 1; end
                1: begin
                    if (dmem_ready)               begin m.st = 0; m.wcnt = 0; end
                    else if (m.wcnt == m.timeout) m.st = 2;
                    else                          m.wcnt++;
                end
                default: ;
            endcase
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.imem_ready = 1'b1;
        s.dmem_ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst             = ($urandom_range(0, 63) == 0);
        s.id_rs           = 5'($urandom_range(0, 3));
        s.id_rt           = 5'($urandom_range(0, 3));
        s.id_uses_rt      = 1'($urandom_range(0, 1));
        s.ex_mem_read     = 1'($urandom_range(0, 1));
        s.ex_rd           = 5'($urandom_range(0, 3));
        s.ex_branch_taken = ($urandom_range(0, 5) == 0);
        s.dmem_req        = ($urandom_range(0, 3) == 0);
        s.dmem_ready      = 1'($urandom_range(0, 1));
        s.imem_ready      = ($urandom_range(0, 3) != 0);
        s.stall_cnt_clr   = ($urandom_range(0, 23) == 0);
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the expected responses.
    task automatic step(input stim_t s);
        logic [26:0] ef, es;
        @(posedge clk);
        #1;
        rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
        ex_mem_read = s.ex_mem_read; ex_rd = s.ex_rd; ex_branch_taken = s.ex_branch_taken;
        dmem_req = s.dmem_req; dmem_ready = s.dmem_ready; imem_ready = s.imem_ready;
        stall_cnt_clr = s.stall_cnt_clr;
        ef = model_expect(mf);
        es = model_expect(ms);
        q_f.push_back(ef);
        q_s.push_back(es);
        model_step(mf, ef[26]);
        model_step(ms, es[26]);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        step(s);
        step(idle());
    endtask

    // Monitor: compares whenever a response is outstanding.
    always @(negedge clk) begin
        logic [26:0] e;
        if (q_f.size() > 0) begin
            e = q_f.pop_front();
            check("sb_full", 32'(act_f), 32'(e));
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            check("sb_small", 32'(act_s), 32'(e));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        mf = '{0, 0, 0, 255, 65535};
        ms = '{0, 0, 0, 4, 3};

        // Reset state
        s = idle(); s.rst = 1'b1;
        step(s);
        step(s);
        #2;
        check("rst_state", 32'(state_f), 0);
        check("rst_err", 32'(err_f), 0);
        check("rst_pc_en", 32'(pc_en_f), 1);
        check("rst_stall_cnt", 32'(stall_cnt_f), 0);
        step(idle());

        // Load-use on rs: one stall cycle, counted
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 5; s.id_rs = 5;
        step(s); #2;
        check("lu_pc_en", 32'(pc_en_f), 0);
        check("lu_if_id_en", 32'(if_id_en_f), 0);
        check("lu_id_ex_flush", 32'(id_ex_flush_f), 1);
        check("lu_ex_mem_en", 32'(ex_mem_en_f), 1);
        step(idle()); #2;
        check("lu_stall_cnt", 32'(stall_cnt_f), 1);
        check("lu_done_pc_en", 32'(pc_en_f), 1);

        // Load to r0 never stalls
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 0; s.id_rs = 0;
        step(s); #2;
        check("r0_pc_en", 32'(pc_en_f), 1);
        check("r0_id_ex_flush", 32'(id_ex_flush_f), 0);

        // rt match only when rt is used
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 7; s.id_rs = 1; s.id_rt = 7; s.id_uses_rt = 1;
        step(s); #2;
        check("rt_used_pc_en", 32'(pc_en_f), 0);
        s.id_uses_rt = 0;
        step(s); #2;
        check("rt_unused_pc_en", 32'(pc_en_f), 1);

        // Branch beats load-use
        s = idle(); s.ex_mem_read = 1; s.ex_rd = 5; s.id_rs = 5; s.ex_branch_taken = 1;
        step(s); #2;
        check("br_if_id_flush", 32'(if_id_flush_f), 1);
        check("br_id_ex_flush", 32'(id_ex_flush_f), 1);
        check("br_pc_en", 32'(pc_en_f), 1);

        // Memory wait of 3 cycles with a branch held in EX
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.dmem_req = 1; s.dmem_ready = 0; s.ex_branch_taken = 1;
            step(s); #2;
            check("mw_state", 32'(state_f), (i == 0) ? 0 : 1);
            check("mw_mem_wb_flush", 32'(mem_wb_flush_f), 1);
            check("mw_if_id_flush", 32'(if_id_flush_f), 0);
            check("mw_ex_mem_en", 32'(ex_mem_en_f), 0);
        end
        s = idle(); s.dmem_req = 1; s.ex_branch_taken = 1;
        step(s); #2;
        check("mw_ready_state", 32'(state_f), 1);
        check("mw_ready_mem_wb_flush", 32'(mem_wb_flush_f), 0);
        check("mw_branch_released", 32'(if_id_flush_f), 1);
        step(idle()); #2;
        check("mw_back_to_run", 32'(state_f), 0);

        // Timeout with TIMEOUT=4
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.dmem_req = 1; s.dmem_ready = 0;
            step(s); #2;
            check("to_state", 32'(state_s), (i == 0) ? 0 : ((i < 5) ? 1 : 2));
        end
        check("to_err", 32'(err_s), 1);
        check("to_pc_en", 32'(pc_en_s), 0);
        check("to_mem_wb_en", 32'(mem_wb_en_s), 0);
        step(idle()); #2;
        check("to_sticky", 32'(state_s), 2);
        s = idle(); s.rst = 1;
        step(s); #2;
        check("to_rst_err", 32'(err_s), 0);
        check("to_rst_pc_en", 32'(pc_en_s), 1);
        step(idle()); #2;
        check("to_after_state", 32'(state_s), 0);
        check("to_after_err", 32'(err_s), 0);

        // Saturation with CNT_W=2, then clear beating a stall
        do_reset();
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.imem_ready = 0;
            step(s);
        end
        step(idle()); #2;
        check("sat_cnt", 32'(stall_cnt_s), 3);
        step(idle()); #2;
        check("sat_hold", 32'(stall_cnt_s), 3);
        s = idle(); s.imem_ready = 0; s.stall_cnt_clr = 1;
        step(s);
        step(idle()); #2;
        check("clr_cnt", 32'(stall_cnt_s), 0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(rand_stim());
        end
        step(idle());

        @(negedge clk);
        #1;
        check("sb_drained", 32'(q_f.size() + q_s.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
